// File: rtl/tl_tx_fc_gate.sv
// TL transmit flow-control gate: holds each TLP at its head beat until partner credits
// and retry-buffer space cover it, then forwards it beat-by-beat to the DLL write port.
module tl_tx_fc_gate #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int CREDIT_DEPTH    = 12
) (
  input  logic                       sclk,
  input  logic                       srst,
  input  logic                       tlp_valid_i,
  output logic                       tlp_ready_o,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
  input  logic                       tlp_sop_i,
  input  logic                       tlp_eop_i,
  input  logic [1:0]                 tlp_type_i,
  input  logic [CREDIT_DEPTH-1:0]    tlp_dcred_i,
  input  logic [RETRY_DEPTH_LG2-1:0] tlp_len_dw_i,
  input  logic [RETRY_DEPTH_LG2-1:0] retry_left_dw_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_p_h_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_p_d_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_np_h_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_cpl_h_i,
  input  logic [CREDIT_DEPTH-1:0]    ep_cl_cpl_d_i,
  input  logic                       ep_cl_en_i,
  output logic [PIPE_DATA_WIDTH-1:0] tl2dll_data_o,
  output logic [2:0]                 tl2dll_en_o,
  output logic [CREDIT_DEPTH-1:0]    cc_p_h_o,
  output logic [CREDIT_DEPTH-1:0]    cc_p_d_o,
  output logic [CREDIT_DEPTH-1:0]    cc_np_h_o,
  output logic [CREDIT_DEPTH-1:0]    cc_np_d_o,
  output logic [CREDIT_DEPTH-1:0]    cc_cpl_h_o,
  output logic [CREDIT_DEPTH-1:0]    cc_cpl_d_o
);

  localparam logic [CREDIT_DEPTH-1:0] HALF = {1'b1, {(CREDIT_DEPTH-1){1'b0}}};
  localparam logic [CREDIT_DEPTH-1:0] ONE  = {{(CREDIT_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {FC_INIT, CHECK, XFER, DROP} state_t;

  state_t state_q, state_d;

  logic [CREDIT_DEPTH-1:0] cl_p_h_q, cl_p_d_q, cl_np_h_q, cl_cpl_h_q, cl_cpl_d_q;
  logic [CREDIT_DEPTH-1:0] cc_p_h_q, cc_p_d_q, cc_np_h_q, cc_cpl_h_q, cc_cpl_d_q;
  logic [CREDIT_DEPTH-1:0] cc_p_h_d, cc_p_d_d, cc_np_h_d, cc_cpl_h_d, cc_cpl_d_d;
  logic [PIPE_DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]                 en_q, en_d;
  logic                       head, pass;

  // Modular "enough credit" test: remaining headroom must not have gone negative.
  function automatic logic fits(input logic [CREDIT_DEPTH-1:0] cl, cc, req);
    logic [CREDIT_DEPTH-1:0] diff;
    diff = cl - (cc + req);
    return diff <= HALF;
  endfunction

  assign head = (state_q == CHECK) && tlp_valid_i && tlp_sop_i;

  always_comb begin
    pass = 1'b0;
    if (retry_left_dw_i >= tlp_len_dw_i) begin
      unique case (tlp_type_i)
        2'd0:    pass = fits(cl_p_h_q, cc_p_h_q, ONE) && fits(cl_p_d_q, cc_p_d_q, tlp_dcred_i);
        2'd1:    pass = fits(cl_np_h_q, cc_np_h_q, ONE);
        2'd2:    pass = fits(cl_cpl_h_q, cc_cpl_h_q, ONE) && fits(cl_cpl_d_q, cc_cpl_d_q, tlp_dcred_i);
        default: pass = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state_q <= FC_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FC_INIT: if (ep_cl_en_i) state_d = CHECK;
      CHECK: begin
        if (head) begin
          if (tlp_type_i == 2'd3) begin
            if (!tlp_eop_i) state_d = DROP;
          end else if (pass) begin
            state_d = XFER;
          end
        end
      end
      XFER:    if (tlp_valid_i && tlp_eop_i) state_d = CHECK;
      DROP:    if (tlp_valid_i && tlp_eop_i) state_d = CHECK;
      default: state_d = FC_INIT;
    endcase
  end

  // In CHECK only stray non-sop beats and illegal-type heads are consumed.
  always_comb begin
    tlp_ready_o = 1'b0;
    unique case (state_q)
      CHECK:      tlp_ready_o = tlp_valid_i && (!tlp_sop_i || tlp_type_i == 2'd3);
      XFER, DROP: tlp_ready_o = 1'b1;
      default:    tlp_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    cc_p_h_d   = cc_p_h_q;
    cc_p_d_d   = cc_p_d_q;
    cc_np_h_d  = cc_np_h_q;
    cc_cpl_h_d = cc_cpl_h_q;
    cc_cpl_d_d = cc_cpl_d_q;
    if (head && pass) begin
      unique case (tlp_type_i)
        2'd0: begin
          cc_p_h_d = cc_p_h_q + ONE;
          cc_p_d_d = cc_p_d_q + tlp_dcred_i;
        end
        2'd1: cc_np_h_d = cc_np_h_q + ONE;
        2'd2: begin
          cc_cpl_h_d = cc_cpl_h_q + ONE;
          cc_cpl_d_d = cc_cpl_d_q + tlp_dcred_i;
        end
        default: ;
      endcase
    end
    en_d   = '0;
    data_d = data_q;
    if (state_q == XFER && tlp_valid_i) begin
      en_d   = {tlp_eop_i, tlp_sop_i, 1'b1};
      data_d = tlp_data_i;
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      cl_p_h_q   <= '0;
      cl_p_d_q   <= '0;
      cl_np_h_q  <= '0;
      cl_cpl_h_q <= '0;
      cl_cpl_d_q <= '0;
      cc_p_h_q   <= '0;
      cc_p_d_q   <= '0;
      cc_np_h_q  <= '0;
      cc_cpl_h_q <= '0;
      cc_cpl_d_q <= '0;
      data_q     <= '0;
      en_q       <= '0;
    end else begin
      if (ep_cl_en_i) begin
        cl_p_h_q   <= ep_cl_p_h_i;
        cl_p_d_q   <= ep_cl_p_d_i;
        cl_np_h_q  <= ep_cl_np_h_i;
        cl_cpl_h_q <= ep_cl_cpl_h_i;
        cl_cpl_d_q <= ep_cl_cpl_d_i;
      end
      cc_p_h_q   <= cc_p_h_d;
      cc_p_d_q   <= cc_p_d_d;
      cc_np_h_q  <= cc_np_h_d;
      cc_cpl_h_q <= cc_cpl_h_d;
      cc_cpl_d_q <= cc_cpl_d_d;
      data_q     <= data_d;
      en_q       <= en_d;
    end
  end

  assign tl2dll_data_o = data_q;
  assign tl2dll_en_o   = en_q;
  assign cc_p_h_o      = cc_p_h_q;
  assign cc_p_d_o      = cc_p_d_q;
  assign cc_np_h_o     = cc_np_h_q;
  assign cc_np_d_o     = '0;
  assign cc_cpl_h_o    = cc_cpl_h_q;
  assign cc_cpl_d_o    = cc_cpl_d_q;

endmodule
